// File: rtl/uart_pkg.sv
// Shared UART definitions: baud select codes, divisor math, receiver
// FSM encoding and the oversampling tick indices used for bit decisions.
package uart_pkg;

    // Baud_sel encodings; codes 5-7 fall back to 9600.
    typedef enum logic [2:0] {
        BAUD_9600   = 3'd0,
        BAUD_19200  = 3'd1,
        BAUD_38400  = 3'd2,
        BAUD_57600  = 3'd3,
        BAUD_115200 = 3'd4
    } baud_sel_e;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    localparam int unsigned OVERSAMPLE = 16;

    // Tick index within a bit (1..15, then 0 closes the bit).
    localparam logic [3:0] SAMPLE_T0 = 4'd6;
    localparam logic [3:0] SAMPLE_T1 = 4'd7;
    localparam logic [3:0] SAMPLE_T2 = 4'd8;
    localparam logic [3:0] DECIDE_T  = 4'd9;
    localparam logic [3:0] LAST_T    = 4'd15;
    localparam logic [2:0] LAST_BIT  = 3'd7;

    // Divider reload value: round(clk/(baud*16)) - 1, floored at 0.
    function automatic int unsigned baud_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        int unsigned q;
        q = (clk_freq + baud * (OVERSAMPLE / 2)) / (baud * OVERSAMPLE);
        return (q == 0) ? 0 : q - 1;
    endfunction

    // 2-of-3 vote over the three mid-bit samples.
    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// 16x oversampling tick generator. The rate is latched on clr so a frame
// keeps one rate; a transmitter can count 16 ticks to get its 1x bit tick.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [2:0] baud_sel,
    input  logic       clr,
    output logic       tick
);

    // 9600 has the largest divisor, so it sizes the counter.
    localparam int unsigned DIV_MAX = baud_div(CLK_FREQ, 9600);
    localparam int unsigned CW      = (DIV_MAX < 2) ? 1 : $clog2(DIV_MAX + 1);

    localparam logic [CW-1:0] DIV_9600   = CW'(baud_div(CLK_FREQ, 9600));
    localparam logic [CW-1:0] DIV_19200  = CW'(baud_div(CLK_FREQ, 19200));
    localparam logic [CW-1:0] DIV_38400  = CW'(baud_div(CLK_FREQ, 38400));
    localparam logic [CW-1:0] DIV_57600  = CW'(baud_div(CLK_FREQ, 57600));
    localparam logic [CW-1:0] DIV_115200 = CW'(baud_div(CLK_FREQ, 115200));

    logic [2:0]    sel_q, sel_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] div_val;

    // Reload value for the latched rate.
    always_comb begin
        div_val = DIV_9600;
        case (baud_sel_e'(sel_q))
            BAUD_19200:  div_val = DIV_19200;
            BAUD_38400:  div_val = DIV_38400;
            BAUD_57600:  div_val = DIV_57600;
            BAUD_115200: div_val = DIV_115200;
            default:     div_val = DIV_9600;
        endcase
    end

    assign tick = ~clr & (cnt_q == div_val);

    // Divider count and rate latch; clr restarts the phase at the start edge.
    always_comb begin
        sel_d = sel_q;
        cnt_d = cnt_q + CW'(1);
        if (clr) begin
            sel_d = baud_sel;
            cnt_d = '0;
        end else if (cnt_q == div_val) begin
            cnt_d = '0;
        end
    end

    // Divider state registers.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sel_q <= '0;
            cnt_q <= '0;
        end else begin
            sel_q <= sel_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver, LSB first, 16x oversampled with a 3-sample
// majority vote per bit. Reports good bytes and stop-bit framing errors.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [2:0] Baud_sel,
    input  logic       Uart_rx,
    output logic [7:0] Data_byte,
    output logic       Rx_done,
    output logic       Frame_err,
    output logic       Uart_state
);

    // sync_q[0..1] synchroniser, sync_q[2] holds the previous value for edges.
    logic [2:0] sync_q, sync_d;
    logic       rx_s, fall;

    rx_state_e  state_q, state_d;
    logic [3:0] tick_cnt_q, tick_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [2:0] samp_q, samp_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_byte_q, data_byte_d;
    logic       rx_done_q, rx_done_d;
    logic       frame_err_q, frame_err_d;
    logic       uart_state_q, uart_state_d;

    logic       tick, baud_clr, in_bit;
    logic [3:0] tick_idx;
    logic       maj;

    // Shift the raw line into the synchroniser / edge-detect chain.
    always_comb begin
        sync_d = {sync_q[1:0], Uart_rx};
    end

    assign rx_s     = sync_q[1];
    assign fall     = sync_q[2] & ~sync_q[1];
    assign baud_clr = (state_q == ST_IDLE) & fall;

    uart_baud_tick #(
        .CLK_FREQ (CLK_FREQ)
    ) u_baud (
        .Clk      (Clk),
        .Rst      (Rst),
        .baud_sel (Baud_sel),
        .clr      (baud_clr),
        .tick     (tick)
    );

    // tick_idx is the position of the current tick inside the bit; it wraps
    // to 0 on the 16th tick, which is the bit boundary.
    assign tick_idx = tick_cnt_q + 4'd1;
    assign in_bit   = (state_q == ST_START) | (state_q == ST_DATA) |
                      (state_q == ST_STOP);
    assign maj      = maj3(samp_q);

    // Next-state, sampling and output-pulse logic.
    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        samp_d      = samp_q;
        shift_d     = shift_q;
        data_byte_d = data_byte_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;

        if (tick && in_bit) begin
            tick_cnt_d = tick_idx;
            case (tick_idx)
                SAMPLE_T0: samp_d[0] = rx_s;
                SAMPLE_T1: samp_d[1] = rx_s;
                SAMPLE_T2: samp_d[2] = rx_s;
                default:   ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d    = ST_START;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    samp_d     = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    // A start bit that reads high mid-bit was only a glitch.
                    if (tick_idx == DECIDE_T && maj) begin
                        state_d = ST_IDLE;
                    end else if (tick_cnt_q == LAST_T) begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (tick_idx == DECIDE_T) begin
                        shift_d = {maj, shift_q[7:1]};
                    end
                    if (tick_cnt_q == LAST_T) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d   = ST_STOP;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
            end
            ST_STOP: begin
                // Leave mid-stop-bit so a following start edge is not missed.
                if (tick && tick_idx == DECIDE_T) begin
                    if (maj) begin
                        data_byte_d = shift_q;
                        rx_done_d   = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // Hold off until the line is released so a break is one error.
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        uart_state_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sync_q       <= 3'b111;
            state_q      <= ST_IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            samp_q       <= '0;
            shift_q      <= '0;
            data_byte_q  <= '0;
            rx_done_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            uart_state_q <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            samp_q       <= samp_d;
            shift_q      <= shift_d;
            data_byte_q  <= data_byte_d;
            rx_done_q    <= rx_done_d;
            frame_err_q  <= frame_err_d;
            uart_state_q <= uart_state_d;
        end
    end

    assign Data_byte  = data_byte_q;
    assign Rx_done    = rx_done_q;
    assign Frame_err  = frame_err_q;
    assign Uart_state = uart_state_q;

endmodule
